crypto_wallet2_nios_fast_cpu_cpu_div_cell: RTL and testbench
============================================================

CRYPTO_WALLET2_NIOS_FAST_CPU_CPU_DIV_CELL -- requirements
Module: crypto_wallet2_nios_fast_cpu_cpu_div_cell

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width in bits (even, >=4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port en  input  1  pipeline enable; low freezes all internal state and outputs.
REQ-005 SHALL have port start  input  1  request a division; sampled only when en=1 and the block is idle.
REQ-006 SHALL have port div_signed  input  1  1 = two's-complement divide, 0 = unsigned; captured with start.
REQ-007 SHALL have port dividend  input  DATA_W  numerator; captured with start.
REQ-008 SHALL have port divisor  input  DATA_W  denominator; captured with start.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port quotient  output  DATA_W  registered quotient.
REQ-012 SHALL have port remainder  output  DATA_W  registered remainder.
REQ-013 SHALL have port div_by_zero  output  1  registered flag, divisor was zero.

Function
REQ-014 SHALL implement radix-2 restoring division on operand magnitudes, one quotient bit per enabled cycle.
REQ-015 SHALL use states IDLE, ITER, FIX; IDLE->ITER on accepted start, ITER->FIX after DATA_W iterations, FIX->IDLE after one cycle.
REQ-016 SHALL, at accepting edge n (en=1, state IDLE, start=1), capture operands, sign flags and magnitudes, clear the iteration counter, enter ITER.
REQ-017 SHALL perform iterations at edges n+1..n+DATA_W and FIX at edge n+DATA_W+1 (latency DATA_W+1 enabled edges; 33 for DATA_W=32).
REQ-018 SHALL at the FIX edge load quotient, remainder, div_by_zero and assert done for exactly one enabled cycle.
REQ-019 SHALL drive busy=1 from edge n through the FIX edge; busy=0 while done=1.
REQ-020 SHALL accept a new start in the done cycle (back-to-back, no bubble).
REQ-021 SHALL ignore start while busy=1; captured operands unaffected.
REQ-022 SHALL, when en=0, hold state, counter, partial remainder, busy, done and all result outputs unchanged (done stays high if it was high).
REQ-023 SHALL, signed mode: quotient negative iff operand signs differ and magnitude quotient nonzero; remainder takes dividend sign (truncating division).
REQ-024 SHALL, signed -2^(DATA_W-1) / -1, produce quotient=-2^(DATA_W-1), remainder=0, no flag.
REQ-025 SHALL, divisor=0 (either mode), run full latency and produce quotient=all ones, remainder=captured dividend unmodified, div_by_zero=1.
REQ-026 SHALL clear div_by_zero on any completion with nonzero divisor.
REQ-027 SHALL hold quotient/remainder/div_by_zero stable between done pulses.

Reset
REQ-028 SHALL, on reset_n low, immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-029 SHALL abandon any in-flight operation on reset without asserting done afterward.
REQ-030 SHALL accept start on the first rising edge after reset_n deasserts.

Verification
REQ-031 SHALL cover: unsigned 100/7, start at edge n, en=1 -> done at edge n+33, quotient=14, remainder=2, div_by_zero=0.
REQ-032 SHALL cover: signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-033 SHALL cover: 5/0 signed and unsigned -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; next 9/3 -> 3, 0, flag 0.
REQ-034 SHALL cover: start held high continuously with alternating operands -> done every 33 edges, second start during busy ignored, back-to-back start in done cycle accepted.
REQ-035 SHALL cover: en low for 5 cycles mid-ITER on 1000/10 -> done delayed exactly 5 cycles, result 100 rem 0; en low during done -> done stretched.
REQ-036 SHALL cover: reset_n pulsed low at iteration 10 -> outputs 0 immediately, no done within 40 cycles, next start completes correctly.

Source files
------------

// File: rtl/crypto_wallet2_nios_fast_cpu_cpu_div_cell.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, one quotient bit
// per enabled cycle.
module crypto_wallet2_nios_fast_cpu_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prem_q, prem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic              dvd_neg, dvs_neg;
  logic [DATA_W-1:0] dvd_mag, dvs_mag;
  logic [DATA_W:0]   shifted, diff;

  always_comb begin
    dvd_neg = div_signed & dividend[DATA_W-1];
    dvs_neg = div_signed & divisor[DATA_W-1];
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
    shifted = {prem_q, quo_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvsr_q};

    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = done_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    if (en) begin
      case (state_q)
        IDLE: begin
          done_d = 1'b0;
          if (start) begin
            state_d = ITER;
            busy_d  = 1'b1;
            cnt_d   = '0;
            prem_d  = '0;
            quo_d   = dvd_mag;
            dvsr_d  = dvs_mag;
            dvd_d   = dividend;
            negq_d  = dvd_neg ^ dvs_neg;
            negr_d  = dvd_neg;
            zero_d  = (divisor == '0);
          end
        end
        ITER: begin
          // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
          if (!diff[DATA_W]) begin
            prem_d = diff[DATA_W-1:0];
            quo_d  = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            prem_d = shifted[DATA_W-1:0];
            quo_d  = {quo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
        end
        FIX: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (zero_q) begin
            quot_d = '1;
            rem_d  = dvd_q;
            dbz_d  = 1'b1;
          end else begin
            quot_d = negq_q ? (~quo_q + 1'b1) : quo_q;
            rem_d  = negr_q ? (~prem_q + 1'b1) : prem_q;
            dbz_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_crypto_wallet2_nios_fast_cpu_cpu_div_cell.sv
// Directed table-driven bench for the multi-cycle divider, plus hand-written
// sequences for enable stalls, held start and mid-operation reset.
module tb_crypto_wallet2_nios_fast_cpu_cpu_div_cell;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n, en, start, div_signed;
  logic [DATA_W-1:0] dividend, divisor;
  logic              busy, done, div_by_zero;
  logic [DATA_W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  crypto_wallet2_nios_fast_cpu_cpu_div_cell #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .start(start), .div_signed(div_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, q, r;
    logic        dbz;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic s, input logic [31:0] a, b, q, r, input logic z);
    vec_t v;
    v.sgn = s; v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = z;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; returns after the edge on which done rose.
  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 45) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_div(input vec_t v, input string nm);
    int k;
    div_signed = v.sgn; dividend = v.a; divisor = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy_after_start"}, {31'd0, busy}, 32'd1);
    chk({nm, " done_low_after_start"}, {31'd0, done}, 32'd0);
    wait_done(k);
    chk({nm, " latency"}, k, 32'd33);
    chk({nm, " quotient"}, quotient, v.q);
    chk({nm, " remainder"}, remainder, v.r);
    chk({nm, " dbz"}, {31'd0, div_by_zero}, {31'd0, v.dbz});
    chk({nm, " busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k, cnt;
    vecs[0]  = mk(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    vecs[1]  = mk(1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
    vecs[2]  = mk(1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
    vecs[3]  = mk(1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1);
    vecs[4]  = mk(1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1);
    vecs[5]  = mk(1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0);
    vecs[6]  = mk(1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0);
    vecs[7]  = mk(1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0);
    vecs[8]  = mk(1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0);
    vecs[9]  = mk(1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0);
    vecs[10] = mk(1'b1, 32'd1,          32'd2,          32'd0,          32'd1,          1'b0);
    vecs[11] = mk(1'b1, 32'hFFFFFFFF,   32'd2,          32'd0,          32'hFFFFFFFF,   1'b0);
    vecs[12] = mk(1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1);
    vecs[13] = mk(1'b0, 32'd3,          32'd7,          32'd0,          32'd3,          1'b0);

    reset_n = 1'b0; en = 1'b1; start = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0;
    #12;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst quotient", quotient, 32'd0);
    chk("rst remainder", remainder, 32'd0);
    chk("rst dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // Each call launches in the previous done cycle, so the table also exercises back-to-back starts.
    for (int i = 0; i < 14; i++) run_div(vecs[i], $sformatf("vec%0d", i));

    // Start held high: operand change while busy must be ignored.
    @(posedge clk); #1;
    div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    dividend = 32'd1000; divisor = 32'd10;
    wait_done(k);
    chk("hold latency1", k, 32'd33);
    chk("hold q1", quotient, 32'd14);
    chk("hold r1", remainder, 32'd2);
    @(posedge clk); #1;
    chk("hold b2b busy", {31'd0, busy}, 32'd1);
    chk("hold b2b done", {31'd0, done}, 32'd0);
    dividend = 32'd9; divisor = 32'd3;
    wait_done(k);
    chk("hold latency2", k, 32'd33);
    chk("hold q2", quotient, 32'd100);
    chk("hold r2", remainder, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;

    // Five frozen cycles mid-iteration, then a frozen done pulse.
    dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1; en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall busy", {31'd0, busy}, 32'd1);
    en = 1'b1;
    wait_done(k);
    chk("stall latency", k + 15, 32'd38);
    chk("stall q", quotient, 32'd100);
    chk("stall r", remainder, 32'd0);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stretch done", {31'd0, done}, 32'd1);
    chk("stretch q", quotient, 32'd100);
    en = 1'b1;
    @(posedge clk); #1;
    chk("stretch done_drop", {31'd0, done}, 32'd0);
    chk("hold q after done", quotient, 32'd100);

    // Reset in the middle of an operation.
    dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3; reset_n = 1'b0; #1;
    chk("midrst quotient", quotient, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("midrst no_done", cnt, 32'd0);
    run_div(vecs[5], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
